// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform geometry, bit-reversal helper and reader FSM states.
package fft_pkg;

    localparam int N_POINTS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Reverse the ADDR_W-bit address: natural bin k lives at RAM address bitrev(k).
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_skid_buf2.sv
// Two-entry fall-through FIFO between the RAM read data and the output stream.
// When empty, a word being pushed is presented at the head in the same cycle,
// so a free-flowing stream sees no extra latency.
module fft_skid_buf2 #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             bypass;
    logic             store;
    logic             drop;

    assign bypass    = (count_q == 2'd0);
    assign valid     = !bypass || push;
    assign head_data = bypass ? push_data : mem_q[rd_ptr_q];
    // A push consumed directly through the bypass never occupies an entry.
    assign store     = push && !(bypass && pop);
    assign drop      = pop && !bypass;
    assign count     = count_q;

    // Entry storage, ring pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (store) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (drop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({store, drop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fft_bitrev_reader.sv
// Reads the finished FFT result RAM in bit-reversed address order and streams
// the bins out in natural order over a valid/ready interface with backpressure.
module fft_bitrev_reader
    import fft_pkg::*;
#(
    parameter int N_POINTS = fft_pkg::N_POINTS,
    parameter int ADDR_W   = fft_pkg::ADDR_W,
    parameter int DATA_W   = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int                ENTRY_W = DATA_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(N_POINTS - 1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   k_q;
    logic [ADDR_W-1:0]   addr_rev;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [ADDR_W-1:0]   flight_index_q;
    logic                flight_q;
    logic                done_q;
    logic [1:0]          buf_count;
    logic [1:0]          credit;
    logic                buf_valid;
    logic                buf_pop;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                read_fire;
    logic                last_accept;

    // Bit-reverse the natural read counter into the RAM address.
    always_comb begin
        addr_rev = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            addr_rev[i] = k_q[ADDR_W-1-i];
        end
    end

    // Only read when the buffer can absorb every word already requested.
    assign credit      = buf_count + {1'b0, flight_q};
    assign read_fire   = (state_q == STREAM) && (credit < 2'd2);
    assign rd_en       = read_fire;
    assign rd_addr     = read_fire ? addr_rev : last_addr_q;

    assign push_entry  = {rd_data, flight_index_q, (flight_index_q == LAST_K)};
    assign buf_pop     = buf_valid && out_ready;
    assign last_accept = buf_pop && head_entry[0];

    assign out_valid   = buf_valid;
    assign out_data    = buf_valid ? head_entry[ENTRY_W-1 -: DATA_W] : '0;
    assign out_index   = buf_valid ? head_entry[ADDR_W:1] : '0;
    assign out_last    = buf_valid ? head_entry[0] : 1'b0;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

    fft_skid_buf2 #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (flight_q),
        .push_data (push_entry),
        .pop       (buf_pop),
        .valid     (buf_valid),
        .head_data (head_entry),
        .count     (buf_count)
    );

    // Next-state logic: start is honoured only from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (read_fire && (k_q == LAST_K)) state_d = DRAIN;
            DRAIN:   if (last_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read counter plus tag of the word currently in flight from the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q            <= '0;
            last_addr_q    <= '0;
            flight_q       <= 1'b0;
            flight_index_q <= '0;
        end else begin
            flight_q <= read_fire;
            if (read_fire) begin
                flight_index_q <= k_q;
                last_addr_q    <= addr_rev;
            end
            if (state_d == IDLE) begin
                k_q <= '0;
            end else if (read_fire) begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Completion pulse the cycle after the final word is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_accept;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Directed bench for fft_bitrev_reader with a one-cycle-latency result RAM model.
module tb_fft_bitrev_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] ram [32];
    int          checks;
    int          passed;

    fft_bitrev_reader #(
        .N_POINTS (32),
        .ADDR_W   (5),
        .DATA_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Result RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    function automatic logic [4:0] tb_bitrev(input int v);
        logic [4:0] a;
        logic [4:0] r;
        a = v[4:0];
        for (int i = 0; i < 5; i++) r[i] = a[4 - i];
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rd_en, out_valid, out_last, busy, done} !== 5'b0)
            $display("[TB] FAIL reset_ctrl got rd_en=%b valid=%b last=%b busy=%b done=%b want all 0", rd_en, out_valid, out_last, busy, done);
        else passed++;
        checks++;
        if (rd_addr !== 5'd0 || out_index !== 5'd0 || out_data !== 32'd0)
            $display("[TB] FAIL reset_data got rd_addr=%0d index=%0d data=%0h want 0", rd_addr, out_index, out_data);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0; reset = 1'b1;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0)
                $display("[TB] FAIL idle_after_reset c=%0d got busy=%b rd_en=%b want 0 0", c, busy, rd_en);
            else passed++;
        end
    endtask

    task automatic test_stream();
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            start = (c == 0); out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (c >= 1 && c <= 32) begin
                if (rd_en !== 1'b1 || rd_addr !== tb_bitrev(c - 1))
                    $display("[TB] FAIL stream_rd c=%0d got rd_en=%b addr=%0d want 1 %0d", c, rd_en, rd_addr, tb_bitrev(c - 1));
                else passed++;
            end else begin
                if (rd_en !== 1'b0)
                    $display("[TB] FAIL stream_rd_idle c=%0d got rd_en=%b want 0", c, rd_en);
                else passed++;
            end
            checks++;
            if (c >= 2 && c <= 33) begin
                if (out_valid !== 1'b1 || out_index !== 5'(c - 2) || out_data !== {27'd0, tb_bitrev(c - 2)} || out_last !== 1'(c == 33))
                    $display("[TB] FAIL stream_out c=%0d got v=%b idx=%0d data=%0d last=%b want 1 %0d %0d %b", c, out_valid, out_index, out_data, out_last, c - 2, tb_bitrev(c - 2), (c == 33));
                else passed++;
            end else begin
                if (out_valid !== 1'b0)
                    $display("[TB] FAIL stream_out_idle c=%0d got valid=%b want 0", c, out_valid);
                else passed++;
            end
            checks++;
            if (busy !== 1'(c >= 1 && c <= 33) || done !== 1'(c == 34))
                $display("[TB] FAIL stream_status c=%0d got busy=%b done=%b want %b %b", c, busy, done, (c >= 1 && c <= 33), (c == 34));
            else passed++;
        end
    endtask

    task automatic test_random_ready();
        int issued = 0;
        int accepted = 0;
        int dones = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            start = (c == 0); out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (issued - accepted >= 2) begin
                checks++;
                if (rd_en !== 1'b0)
                    $display("[TB] FAIL credit c=%0d got rd_en=%b with %0d outstanding want 0", c, rd_en, issued - accepted);
                else passed++;
            end
            if (rd_en === 1'b1) issued++;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (out_index !== 5'(accepted) || out_data !== {27'd0, tb_bitrev(accepted)} || out_last !== 1'(accepted == 31))
                    $display("[TB] FAIL rand_xfer got idx=%0d data=%0d last=%b want %0d %0d %b", out_index, out_data, out_last, accepted, tb_bitrev(accepted), (accepted == 31));
                else passed++;
                accepted++;
            end
            if (done === 1'b1) dones++;
        end
        checks++;
        if (accepted != 32 || issued != 32 || dones != 1)
            $display("[TB] FAIL rand_totals got xfers=%0d reads=%0d dones=%0d want 32 32 1", accepted, issued, dones);
        else passed++;
    endtask

    task automatic test_stall();
        int nxt = 0;
        int dones = 0;
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == 0); out_ready = !(c >= 5 && c <= 14);
            @(negedge clk);
            if (c >= 5 && c <= 14) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== 5'd3 || out_data !== 32'd24)
                    $display("[TB] FAIL stall_hold c=%0d got v=%b idx=%0d data=%0d want 1 3 24", c, out_valid, out_index, out_data);
                else passed++;
            end
            if (c >= 7 && c <= 14) begin
                checks++;
                if (rd_en !== 1'b0)
                    $display("[TB] FAIL stall_rd c=%0d got rd_en=%b want 0", c, rd_en);
                else passed++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (out_index !== 5'(nxt) || out_data !== {27'd0, tb_bitrev(nxt)} || out_last !== 1'(nxt == 31))
                    $display("[TB] FAIL stall_xfer got idx=%0d data=%0d last=%b want %0d %0d %b", out_index, out_data, out_last, nxt, tb_bitrev(nxt), (nxt == 31));
                else passed++;
                nxt++;
            end
            if (done === 1'b1) dones++;
        end
        checks++;
        if (nxt != 32 || dones != 1)
            $display("[TB] FAIL stall_totals got xfers=%0d dones=%0d want 32 1", nxt, dones);
        else passed++;
    endtask

    task automatic test_second_start();
        for (int run = 0; run < 2; run++) begin
            int nxt = 0;
            for (int c = 0; c <= 40; c++) begin
                @(posedge clk); #1;
                start = (c == 0) || (run == 0 && c == 10); out_ready = 1'b1;
                @(negedge clk);
                if (c == 1) begin
                    checks++;
                    if (rd_en !== 1'b1 || rd_addr !== 5'd0)
                        $display("[TB] FAIL restart_first_rd run=%0d got rd_en=%b addr=%0d want 1 0", run, rd_en, rd_addr);
                    else passed++;
                end
                if (c >= 30) begin
                    checks++;
                    if (done !== 1'(c == 34))
                        $display("[TB] FAIL restart_done run=%0d c=%0d got done=%b want %b", run, c, done, (c == 34));
                    else passed++;
                end
                if (out_valid === 1'b1) begin
                    checks++;
                    if (out_index !== 5'(nxt) || out_data !== {27'd0, tb_bitrev(nxt)})
                        $display("[TB] FAIL restart_xfer run=%0d got idx=%0d data=%0d want %0d %0d", run, out_index, out_data, nxt, tb_bitrev(nxt));
                    else passed++;
                    nxt++;
                end
            end
            checks++;
            if (nxt != 32)
                $display("[TB] FAIL restart_count run=%0d got %0d words want 32", run, nxt);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int nxt = 0;
        for (int c = 0; c <= 18; c++) begin
            @(posedge clk); #1;
            start = (c == 0); out_ready = 1'b1; reset = !(c == 15 || c == 16);
            @(negedge clk);
            if (c == 14) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== 5'd12)
                    $display("[TB] FAIL pre_reset got v=%b idx=%0d want 1 12", out_valid, out_index);
                else passed++;
            end
            if (c == 15) begin
                checks++;
                if ({rd_en, out_valid, out_last, busy, done} !== 5'b0 || rd_addr !== 5'd0 || out_index !== 5'd0 || out_data !== 32'd0)
                    $display("[TB] FAIL mid_reset got rd_en=%b addr=%0d v=%b idx=%0d data=%0d last=%b busy=%b done=%b want all 0", rd_en, rd_addr, out_valid, out_index, out_data, out_last, busy, done);
                else passed++;
            end
            if (c >= 16) begin
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0)
                    $display("[TB] FAIL post_reset_idle c=%0d got busy=%b v=%b want 0 0", c, busy, out_valid);
                else passed++;
            end
        end
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            start = (c == 0); out_ready = 1'b1;
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (out_index !== 5'(nxt) || out_data !== {27'd0, tb_bitrev(nxt)})
                    $display("[TB] FAIL rerun_xfer got idx=%0d data=%0d want %0d %0d", out_index, out_data, nxt, tb_bitrev(nxt));
                else passed++;
                nxt++;
            end
        end
        checks++;
        if (nxt != 32)
            $display("[TB] FAIL rerun_count got %0d words want 32", nxt);
        else passed++;
    endtask

    task automatic test_start_at_last();
        int dones = 0;
        for (int c = 0; c <= 37; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 33); out_ready = 1'b1;
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (c == 33) begin
                checks++;
                if (out_valid !== 1'b1 || out_last !== 1'b1 || out_index !== 5'd31)
                    $display("[TB] FAIL last_word got v=%b last=%b idx=%0d want 1 1 31", out_valid, out_last, out_index);
                else passed++;
            end
            if (c == 34) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0)
                    $display("[TB] FAIL late_start_done got done=%b busy=%b want 1 0", done, busy);
                else passed++;
            end
            if (c >= 35) begin
                checks++;
                if ({done, busy, rd_en} !== 3'b0)
                    $display("[TB] FAIL late_start_ignored c=%0d got done=%b busy=%b rd_en=%b want 0 0 0", c, done, busy, rd_en);
                else passed++;
            end
        end
        checks++;
        if (dones != 1)
            $display("[TB] FAIL late_start_pulses got %0d done pulses want 1", dones);
        else passed++;
    endtask

    // Preload mem[a] = a and run every scenario in turn.
    initial begin
        clk = 1'b0; reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        checks = 0; passed = 0;
        for (int a = 0; a < 32; a++) ram[a] = 32'(a);
        test_reset();
        test_stream();
        test_random_ready();
        test_stall();
        test_second_start();
        test_reset_mid();
        test_start_at_last();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
